// File: rtl/decode_queue.sv
// Instruction decode queue: a DEPTH-entry FIFO of raw instruction words whose head entry
// is presented fully decoded, with flush and a count of retired decodes.
module decode_queue #(
    parameter int unsigned bus      = 32,
    parameter int unsigned DEPTH    = 2,
    parameter bit          SIGN_EXT = 1'b0,
    parameter int unsigned CNT_W    = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [31:0]                instruction,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [1:0]                 FUNTYPE,
    output logic [1:0]                 FUNCODE,
    output logic [3:0]                 RD,
    output logic [3:0]                 RS,
    output logic [3:0]                 RX,
    output logic [bus-1:0]             Imm4,
    output logic [bus-1:0]             Imm19,
    output logic [bus-1:0]             Imm28,
    output logic                       selimm,
    output logic [$clog2(DEPTH):0]     occupancy,
    output logic [CNT_W-1:0]           decode_count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned OW = PW + 1;

    logic [31:0]      mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [OW-1:0]    occ_q;
    logic [CNT_W-1:0] cnt_q;
    logic             push;
    logic             pop;
    logic [31:0]      head;

    // Handshakes depend only on registered occupancy, never on the other side's strobe.
    assign in_ready  = (occ_q < OW'(DEPTH));
    assign out_valid = (occ_q != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            cnt_q    <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= instruction;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
                cnt_q    <= cnt_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   occ_q <= occ_q + 1'b1;
                2'b01:   occ_q <= occ_q - 1'b1;
                default: occ_q <= occ_q;
            endcase
        end
    end

    assign head         = mem_q[rd_ptr_q];
    assign occupancy    = occ_q;
    assign decode_count = cnt_q;

    assign FUNTYPE = head[31:30];
    assign FUNCODE = head[29:28];
    assign RD      = head[27:24];
    assign RS      = head[23:20];
    assign RX      = head[19:16];
    assign selimm  = head[0];

    // Fill with the extension bit first, then overlay the field; this also works for bus == 28.
    always_comb begin
        Imm4        = '0;
        Imm4[3:0]   = head[23:20];
        Imm19       = {bus{SIGN_EXT & head[19]}};
        Imm19[18:0] = head[19:1];
        Imm28       = {bus{SIGN_EXT & head[27]}};
        Imm28[27:0] = head[27:0];
    end

endmodule

// File: tb/tb_decode_queue.sv
// Directed bench for decode_queue: a zero-extending 16-bit-count instance and a
// sign-extending 4-bit-count instance driven by the same stimulus.
module tb_decode_queue;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, out_ready;
    logic [31:0] instruction;

    logic        in_ready_a, out_valid_a, selimm_a;
    logic [1:0]  funtype_a, funcode_a, occ_a;
    logic [3:0]  rd_a, rs_a, rx_a;
    logic [31:0] imm4_a, imm19_a, imm28_a;
    logic [15:0] cnt_a;

    logic        in_ready_b, out_valid_b, selimm_b;
    logic [1:0]  funtype_b, funcode_b, occ_b;
    logic [3:0]  rd_b, rs_b, rx_b;
    logic [31:0] imm4_b, imm19_b, imm28_b;
    logic [3:0]  cnt_b;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    decode_queue #(.bus(32), .DEPTH(2), .SIGN_EXT(1'b0), .CNT_W(16)) dut_a (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_a),
        .instruction(instruction), .out_valid(out_valid_a), .out_ready(out_ready),
        .FUNTYPE(funtype_a), .FUNCODE(funcode_a), .RD(rd_a), .RS(rs_a), .RX(rx_a),
        .Imm4(imm4_a), .Imm19(imm19_a), .Imm28(imm28_a), .selimm(selimm_a),
        .occupancy(occ_a), .decode_count(cnt_a)
    );

    decode_queue #(.bus(32), .DEPTH(2), .SIGN_EXT(1'b1), .CNT_W(4)) dut_b (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_b),
        .instruction(instruction), .out_valid(out_valid_b), .out_ready(out_ready),
        .FUNTYPE(funtype_b), .FUNCODE(funcode_b), .RD(rd_b), .RS(rs_b), .RX(rx_b),
        .Imm4(imm4_b), .Imm19(imm19_b), .Imm28(imm28_b), .selimm(selimm_b),
        .occupancy(occ_b), .decode_count(cnt_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [31:0] w;

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; instruction = '0;
        tick();
        tick();
        rst = 1'b0;
        chk("reset out_valid", 64'(out_valid_a), 64'd0);
        chk("reset in_ready", 64'(in_ready_a), 64'd1);
        chk("reset occupancy", 64'(occ_a), 64'd0);
        chk("reset count", 64'(cnt_a), 64'd0);
        chk("reset imm28", 64'(imm28_a), 64'd0);

        // Single push, consumer stalled
        in_valid = 1'b1; instruction = 32'h5A3C_F001;
        tick();
        chk("push out_valid", 64'(out_valid_a), 64'd1);
        chk("push funtype", 64'(funtype_a), 64'd1);
        chk("push funcode", 64'(funcode_a), 64'd1);
        chk("push rd", 64'(rd_a), 64'hA);
        chk("push rs", 64'(rs_a), 64'h3);
        chk("push rx", 64'(rx_a), 64'hC);
        chk("push selimm", 64'(selimm_a), 64'd1);
        chk("push imm4", 64'(imm4_a), 64'h3);
        chk("push imm28", 64'(imm28_a), 64'h0A3C_F001);
        chk("push imm19 zext", 64'(imm19_a), 64'h0006_7800);
        chk("push imm19 sext", 64'(imm19_b), 64'hFFFE_7800);
        chk("push occupancy", 64'(occ_a), 64'd1);

        // Fill, then offer a third word alongside a pop
        instruction = 32'h1111_1112;
        tick();
        chk("full occupancy", 64'(occ_a), 64'd2);
        chk("full in_ready", 64'(in_ready_a), 64'd0);
        chk("full head held", 64'(imm28_a), 64'h0A3C_F001);
        instruction = 32'h2222_2223; out_ready = 1'b1;
        tick();
        chk("refuse occupancy", 64'(occ_a), 64'd1);
        chk("drain order 2nd", 64'(imm28_a), 64'h0111_1112);
        in_valid = 1'b0;
        tick();
        chk("drained out_valid", 64'(out_valid_a), 64'd0);
        chk("drained count", 64'(cnt_a), 64'd2);

        // Streaming across pointer wrap
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            w = 32'h4000_0000 | (32'(i) << 24) | 32'(i * 3 + 1);
            instruction = w;
            tick();
            chk("stream head", {32'h0, funtype_a, funcode_a, imm28_a[27:0]}, 64'(w));
            chk("stream occupancy", 64'(occ_a), 64'd1);
        end
        in_valid = 1'b0;
        tick();
        chk("stream empty", 64'(out_valid_a), 64'd0);
        chk("stream count", 64'(cnt_a), 64'd12);
        chk("stream count b", 64'(cnt_b), 64'd12);

        // Extension of a word with both sign bits set
        out_ready = 1'b0; in_valid = 1'b1; instruction = 32'h0808_0000;
        tick();
        chk("zext imm19", 64'(imm19_a), 64'h0004_0000);
        chk("zext imm28", 64'(imm28_a), 64'h0808_0000);
        chk("sext imm19", 64'(imm19_b), 64'hFFFC_0000);
        chk("sext imm28", 64'(imm28_b), 64'hF808_0000);
        chk("sext imm4", 64'(imm4_b), 64'd0);

        // Flush with a concurrent push and pop
        instruction = 32'h1234_5678;
        tick();
        chk("preflush occupancy", 64'(occ_a), 64'd2);
        flush = 1'b1; out_ready = 1'b1; instruction = 32'hDEAD_BEEF;
        tick();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        chk("flush out_valid", 64'(out_valid_a), 64'd0);
        chk("flush occupancy", 64'(occ_a), 64'd0);
        chk("flush count", 64'(cnt_a), 64'd12);
        in_valid = 1'b1; instruction = 32'h3333_3330;
        tick();
        in_valid = 1'b0;
        chk("postflush head", 64'(imm28_a), 64'h0333_3330);
        chk("postflush occupancy", 64'(occ_a), 64'd1);
        out_ready = 1'b1;
        tick();
        chk("postflush count", 64'(cnt_a), 64'd13);

        // Narrow counter wraps 15 -> 0
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            instruction = 32'h0500_0000 + 32'(i);
            tick();
        end
        chk("count b at 15", 64'(cnt_b), 64'd15);
        in_valid = 1'b0;
        tick();
        chk("count b wrap", 64'(cnt_b), 64'd0);
        chk("count a 16", 64'(cnt_a), 64'd16);

        // Reset mid-stream beats flush
        out_ready = 1'b0; in_valid = 1'b1; instruction = 32'hC7F0_0001;
        tick();
        instruction = 32'hB6E0_0003;
        tick();
        chk("prereset occupancy", 64'(occ_a), 64'd2);
        rst = 1'b1; flush = 1'b1; out_ready = 1'b1; instruction = 32'hFFFF_FFFF;
        tick();
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        chk("rst out_valid", 64'(out_valid_a), 64'd0);
        chk("rst in_ready", 64'(in_ready_a), 64'd1);
        chk("rst occupancy", 64'(occ_a), 64'd0);
        chk("rst count a", 64'(cnt_a), 64'd0);
        chk("rst count b", 64'(cnt_b), 64'd0);
        chk("rst funtype", 64'(funtype_a), 64'd0);
        chk("rst selimm", 64'(selimm_a), 64'd0);
        chk("rst imm28 b", 64'(imm28_b), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/decode_queue.md
Name: decode_queue

Overview:
- Buffered, parametrised successor to the combinational instruction decoder.
- Accepts 32-bit instructions over a valid/ready handshake and holds them in a DEPTH-entry FIFO.
- Presents the head entry fully decoded (function type/code, register indices, extended immediates, immediate select) to the execute stage over a second valid/ready handshake.
- Adds selectable immediate sign extension, a pipeline flush and a retired-decode counter.

Parameters:
- bus, 32, width of the extended immediate outputs (must be >= 28).
- DEPTH, 2, FIFO entries (power of two, >= 2).
- SIGN_EXT, 0, 0: zero-extend Imm19/Imm28; 1: sign-extend Imm19 from bit 18 and Imm28 from bit 27.
- CNT_W, 16, width of the decode counter.

Ports:
- clk, input, 1, clock; all state updates on rising edge.
- rst, input, 1, synchronous active-high reset.
- flush, input, 1, synchronous discard of all queued entries.
- in_valid, input, 1, instruction offered.
- in_ready, output, 1, queue can accept an instruction.
- instruction, input, 32, raw instruction word.
- out_valid, output, 1, head entry valid.
- out_ready, input, 1, consumer accepts head.
- FUNTYPE, output, 2, instruction[31:30] of head.
- FUNCODE, output, 2, instruction[29:28] of head.
- RD, output, 4, instruction[27:24] of head.
- RS, output, 4, instruction[23:20] of head.
- RX, output, 4, instruction[19:16] of head.
- Imm4, output, bus, instruction[23:20] zero-extended (never sign-extended).
- Imm19, output, bus, instruction[19:1] extended per SIGN_EXT.
- Imm28, output, bus, instruction[27:0] extended per SIGN_EXT.
- selimm, output, 1, instruction[0] of head.
- occupancy, output, $clog2(DEPTH)+1, number of queued entries.
- decode_count, output, CNT_W, number of completed output handshakes.

Behaviour:
- Single clock domain. Reset is synchronous and active-high: rst sampled on the rising edge of clk.
- Reset:
  - Pointers, occupancy and decode_count clear to 0.
  - out_valid=0 and in_ready=1 from the first edge after rst=1.
  - Decoded field outputs are don't-care while out_valid=0, but must not be X (storage is cleared to 0, so all fields read 0).
- Push: in_valid && in_ready at an edge writes instruction at the write pointer; write pointer += 1 mod DEPTH.
- Pop: out_valid && out_ready at an edge advances the read pointer mod DEPTH; decode_count += 1, wrapping at 2^CNT_W to 0.
- Latency:
  - An instruction pushed into an empty queue appears with out_valid=1 in the next cycle.
  - No combinational path from instruction to outputs.
  - No combinational path from out_ready to in_ready.
- Handshake signals:
  - in_ready = (occupancy < DEPTH). It depends only on state, never on out_ready, so a full queue refuses input even when a pop happens in the same cycle.
  - out_valid = (occupancy != 0).
- Occupancy update per edge:
  - push only: +1.
  - pop only: -1.
  - push and pop together (possible only when 0 < occupancy < DEPTH): unchanged, both pointers advance.
- Decoded outputs are a pure function of the head entry; they stay stable while out_valid=1 and out_ready=0.
- Flush:
  - At an edge with flush=1 (and rst=0), pointers and occupancy go to 0.
  - Any concurrent push is dropped.
  - A concurrent pop is not counted (decode_count unchanged).
  - out_valid=0 in the next cycle.
- rst has priority over flush. Reset mid-stream discards everything and also clears decode_count; flush never clears decode_count.
- Wrap-around: pointers wrap modulo DEPTH; FIFO order is preserved across the wrap.
- Protocol violations:
  - in_valid while in_ready=0: the instruction is ignored and state is unchanged.
  - out_ready while out_valid=0: no effect.
- Extension:
  - SIGN_EXT=0: upper bits of Imm19 and Imm28 are 0.
  - SIGN_EXT=1: upper bits replicate instruction[19] (Imm19 sign) and instruction[27] (Imm28 sign).
  - Imm4 upper bits are always 0.

Test Plan:
- Reset then single push of 32'h5A3C_F001 with out_ready=0 -> next cycle out_valid=1, FUNTYPE=2'b01, FUNCODE=2'b01, RD=4'hA, RS=4'h3, RX=4'hC, selimm=1, Imm4=32'h3, Imm28=32'h0A3C_F001, occupancy=1.
- Fill DEPTH=2 with out_ready=0 -> occupancy=2, in_ready=0; a third offer in the same cycle as a pop is refused; then drain two -> words emerge in order, decode_count=2.
- Continuous streaming with in_valid=out_ready=1 for 10 words -> one word per cycle after 1-cycle latency, order preserved across pointer wrap, occupancy stays at 1, decode_count=10.
- SIGN_EXT=1, instruction 32'h0808_0000 -> Imm19=32'hFFFC_0000, Imm28=32'hF808_0000, Imm4=0; same word with SIGN_EXT=0 -> Imm19=32'h0004_0000, Imm28=32'h0808_0000.
- Two entries queued, assert flush together with in_valid and out_ready -> next cycle out_valid=0, occupancy=0, decode_count unchanged, pushed word absent.
- decode_count at 2^CNT_W-1 (CNT_W=4, value 15) plus one pop -> 0; rst asserted mid-stream with flush=1 -> all outputs at reset values, in_ready=1.
